// File: rtl/switch_conditioner.sv
// Synchronize, debounce and edge-detect raw switch levels; bit WIDTH-1 feeds the mux select.
// Define SW_COND_TOGGLE_EN to turn the select bit into a press-to-toggle latch.
module switch_conditioner #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Counter only runs while the synchronized level disagrees with the clean level.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]   = '0;
      clean_d[i] = clean_q[i];
      rise_d[i]  = 1'b0;
      fall_d[i]  = 1'b0;
      if (s2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = s2_q[i];
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= sw_raw;
      s2_q    <= s1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef SW_COND_TOGGLE_EN
  logic tog_q, tog_d;
  logic tog_rise_q, tog_rise_d;
  logic tog_fall_q, tog_fall_d;

  // Latch flips one cycle after each accepted press of the select bit.
  always_comb begin
    tog_d      = tog_q;
    tog_rise_d = 1'b0;
    tog_fall_d = 1'b0;
    if (rise_q[WIDTH-1]) begin
      tog_d      = ~tog_q;
      tog_rise_d = ~tog_q;
      tog_fall_d = tog_q;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tog_q      <= 1'b0;
      tog_rise_q <= 1'b0;
      tog_fall_q <= 1'b0;
    end else begin
      tog_q      <= tog_d;
      tog_rise_q <= tog_rise_d;
      tog_fall_q <= tog_fall_d;
    end
  end

  always_comb begin
    sw_clean           = clean_q;
    sw_rise            = rise_q;
    sw_fall            = fall_q;
    sw_clean[WIDTH-1]  = tog_q;
    sw_rise[WIDTH-1]   = tog_rise_q;
    sw_fall[WIDTH-1]   = tog_fall_q;
  end
`else
  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Randomized and directed bench for switch_conditioner against a sample-history reference model.
module tb_switch_conditioner;

  localparam int W = 3;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;

  switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b1;
  int rise_cnt [W];
  int fall_cnt [W];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: keeps every raw sample since reset; the synchronized level seen at
  // edge n is the raw sample of edge n-2. A bit is accepted when the last D synchronized
  // values all disagree with the clean level and D edges have passed since its last change.
  logic [W-1:0] rlog [$];
  logic [W-1:0] slog [$];
  logic [W-1:0] m_clean, m_irise;
  logic [W-1:0] exp_clean, exp_rise, exp_fall;
  logic         m_tog;
  int           lastf [W];

  task automatic model_reset();
    rlog.delete();
    slog.delete();
    m_clean = '0;
    m_irise = '0;
    m_tog   = 1'b0;
    for (int b = 0; b < W; b++) lastf[b] = -1;
  endtask

  task automatic model_step(input logic [W-1:0] raw);
    logic [W-1:0] s2u, nr, nf;
    logic         other, prev, tr, tf;
    int           n;
    s2u = (rlog.size() >= 2) ? rlog[rlog.size()-2] : '0;
    rlog.push_back(raw);
    slog.push_back(s2u);
    n  = slog.size() - 1;
    nr = '0;
    nf = '0;
    for (int b = 0; b < W; b++) begin
      if (n - lastf[b] >= D) begin
        other = 1'b1;
        for (int j = 0; j < D; j++)
          if (slog[n-j][b] == m_clean[b]) other = 1'b0;
        if (other) begin
          lastf[b] = n;
          if (m_clean[b]) nf[b] = 1'b1;
          else            nr[b] = 1'b1;
          m_clean[b] = ~m_clean[b];
        end
      end
    end
    prev = m_irise[W-1];
    tr   = prev & ~m_tog;
    tf   = prev & m_tog;
    if (prev) m_tog = ~m_tog;
    m_irise   = nr;
    exp_clean = m_clean;
    exp_rise  = nr;
    exp_fall  = nf;
`ifdef SW_COND_TOGGLE_EN
    exp_clean[W-1] = m_tog;
    exp_rise[W-1]  = tr;
    exp_fall[W-1]  = tf;
`endif
  endtask

  always @(posedge clk) begin
    #1;
    if (reset) begin
      model_reset();
      if (chk_en) check_eq("rst_out", {sw_clean, sw_rise, sw_fall}, '0);
    end else begin
      model_step(sw_raw);
      if (chk_en) begin
        check_eq("clean", sw_clean, exp_clean);
        check_eq("rise",  sw_rise,  exp_rise);
        check_eq("fall",  sw_fall,  exp_fall);
      end
      for (int b = 0; b < W; b++) begin
        if (sw_rise[b]) rise_cnt[b]++;
        if (sw_fall[b]) fall_cnt[b]++;
      end
    end
  end

  // Counts edges from the first sampling edge until the requested pulse appears (bounded).
  task automatic lat_pulse(input int b, input bit want_rise, output int e);
    e = 0;
    do begin
      @(posedge clk);
      #2;
      e++;
    end while (!(want_rise ? sw_rise[b] : sw_fall[b]) && e < 30);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  localparam logic [W-1:0] SIM_EXP =
`ifdef SW_COND_TOGGLE_EN
    3'b001;
`else
    3'b101;
`endif

  initial begin
    int e, r0, f0, rst_left;
    for (int b = 0; b < W; b++) begin
      rise_cnt[b] = 0;
      fall_cnt[b] = 0;
    end
    reset  = 1'b1;
    sw_raw = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Async reset while all outputs are high, then latency from release with input held
    @(negedge clk) sw_raw = 3'b111;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_eq("async_rst", {sw_clean, sw_rise, sw_fall}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lat_pulse(0, 1'b1, e);
    check_eq("rst_lat", e, 6);
    check_eq("rst_rise", sw_rise[1:0], 2'b11);

    // Clean step on bit 0, both directions
    @(negedge clk) sw_raw = '0;
    repeat (10) @(negedge clk);
    sw_raw = 3'b001;
    lat_pulse(0, 1'b1, e);
    check_eq("step_rise_lat", e, 6);
    check_eq("step_clean1", sw_clean[0], 1'b1);
    @(posedge clk);
    #2 check_eq("rise_width", sw_rise[0], 1'b0);
    repeat (4) @(negedge clk);
    sw_raw = '0;
    lat_pulse(0, 1'b0, e);
    check_eq("step_fall_lat", e, 6);
    check_eq("step_clean0", sw_clean[0], 1'b0);

    // Bounce rejection on bit 1: 3 high / 1 low
    repeat (4) @(negedge clk);
    r0 = rise_cnt[1];
    f0 = fall_cnt[1];
    for (int i = 0; i < 40; i++) begin
      @(negedge clk) sw_raw[1] = ((i % 4) != 3);
    end
    @(negedge clk) sw_raw[1] = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("bounce_clean", sw_clean[1], 1'b0);
    check_eq("bounce_pulses", (rise_cnt[1] - r0) + (fall_cnt[1] - f0), 0);

    // Simultaneous change of bits 0 and 2
    sw_raw = 3'b101;
    lat_pulse(0, 1'b1, e);
    check_eq("sim_lat", e, 6);
    check_eq("sim_rise", sw_rise, SIM_EXP);
    check_eq("sim_bit1", sw_clean[1], 1'b0);
    @(negedge clk) sw_raw = '0;
    repeat (10) @(negedge clk);

    // Reset in the middle of a count
    r0 = rise_cnt[0];
    sw_raw = 3'b001;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_nopulse", rise_cnt[0] - r0, 0);
    reset = 1'b0;
    lat_pulse(0, 1'b1, e);
    check_eq("midrst_lat", e, 6);
    @(negedge clk) sw_raw = '0;
    repeat (10) @(negedge clk);

`ifdef SW_COND_TOGGLE_EN
    for (int p = 0; p < 3; p++) begin
      sw_raw[2] = 1'b1;
      repeat (8) @(negedge clk);
      sw_raw[2] = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("tog_state", sw_clean[2], (p % 2 == 0) ? 1'b1 : 1'b0);
    end
`endif

    // Randomized bouncing with occasional resets
    rst_left = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        reset    = 1'b1;
        rst_left = $urandom_range(1, 3);
      end
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 9) < (((i / 100) % 2 == 1) ? 1 : 3)) sw_raw[b] = ~sw_raw[b];
    end
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
